// File: rtl/coherence_bus_arbiter.sv
// Snoopy MSI bus arbiter for CPUS caches sharing one RAM port. Data misses and
// write-backs are granted round-robin, and a Modified owner forwards the block cache-to-cache.
`timescale 1ns/1ps
module coherence_bus_arbiter #(
    parameter int CPUS        = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int BLOCK_WORDS = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CPUS-1:0]    halted,
    input  logic [CPUS-1:0]    iREN,
    input  logic [CPUS*AW-1:0] iaddr,
    output logic [CPUS-1:0]    iwait,
    output logic [CPUS*DW-1:0] iload,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [CPUS*AW-1:0] daddr,
    input  logic [CPUS*DW-1:0] dstore,
    output logic [CPUS-1:0]    dwait,
    output logic [CPUS*DW-1:0] dload,
    input  logic [CPUS-1:0]    cctrans,
    input  logic [CPUS-1:0]    ccwrite,
    input  logic [CPUS-1:0]    cchit,
    output logic [CPUS-1:0]    ccwait,
    output logic [CPUS-1:0]    ccinv,
    output logic [CPUS*AW-1:0] ccsnoopaddr,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic               ramready
);
    localparam int PW = $clog2(CPUS);
    localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(CPUS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        SNOOP  = 3'd2,
        WB     = 3'd3,
        MEM    = 3'd4,
        C2C    = 3'd5,
        IFETCH = 3'd6
    } state_t;

    function automatic logic [CPUS-1:0] onehot(input logic [PW-1:0] idx);
        return {{(CPUS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Returns {found, index} of the first set bit strictly after ptr, wrapping; ptr itself is last.
    function automatic logic [PW:0] rr_pick(input logic [CPUS-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0]     res;
        logic [CPUS-1:0] sh;
        int              idx;
        res = {(PW+1){1'b0}};
        for (int k = CPUS; k >= 1; k--) begin
            idx = (int'(ptr) + k >= CPUS) ? int'(ptr) + k - CPUS : int'(ptr) + k;
            sh  = req >> idx;
            res = sh[0] ? {1'b1, idx[PW-1:0]} : res;
        end
        return res;
    endfunction

    function automatic logic [PW:0] low_pick(input logic [CPUS-1:0] req);
        logic [PW:0]     res;
        logic [CPUS-1:0] sh;
        res = {(PW+1){1'b0}};
        for (int k = CPUS - 1; k >= 0; k--) begin
            sh  = req >> k;
            res = sh[0] ? {1'b1, PW'(k)} : res;
        end
        return res;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [PW-1:0]   drr_r, drr_s, irr_r, irr_s;
    logic [PW-1:0]   gnt_r, gnt_s, own_r, own_s;
    logic [CPUS-1:0] peer_r, peer_s;
    logic            inv_r, inv_s;

    logic [AW-1:0]   daddr_a  [CPUS];
    logic [DW-1:0]   dstore_a [CPUS];
    logic [AW-1:0]   iaddr_a  [CPUS];
    logic [CPUS-1:0] d_elig_s, i_elig_s, gnt_oh_s, own_oh_s, peer_set_s;
    logic [PW:0]     d_pick_s, i_pick_s, hit_pick_s;
    logic [AW-1:0]   gnt_addr_s, gnt_iaddr_s;
    logic [DW-1:0]   gnt_store_s, own_store_s;
    logic            g_write_s, req_ok_s, fwd_s;

    for (genvar j = 0; j < CPUS; j++) begin : g_core
        assign daddr_a[j]  = daddr[j*AW +: AW];
        assign dstore_a[j] = dstore[j*DW +: DW];
        assign iaddr_a[j]  = iaddr[j*AW +: AW];
        assign dload[j*DW +: DW]       = (fwd_s && gnt_oh_s[j]) ? own_store_s : ramload;
        assign iload[j*DW +: DW]       = ramload;
        assign ccsnoopaddr[j*AW +: AW] = ccwait[j] ? gnt_addr_s : {AW{1'b0}};
    end

    assign d_elig_s    = (dREN | dWEN) & ~halted;
    assign i_elig_s    = iREN & ~halted;
    assign d_pick_s    = rr_pick(d_elig_s, drr_r);
    assign i_pick_s    = rr_pick(i_elig_s, irr_r);
    assign gnt_oh_s    = onehot(gnt_r);
    assign own_oh_s    = onehot(own_r);
    assign peer_set_s  = ~halted & ~gnt_oh_s;
    assign hit_pick_s  = low_pick(cchit & peer_set_s);
    assign gnt_addr_s  = daddr_a[gnt_r];
    assign gnt_iaddr_s = iaddr_a[gnt_r];
    assign gnt_store_s = dstore_a[gnt_r];
    assign own_store_s = dstore_a[own_r];
    assign g_write_s   = |(gnt_oh_s & cctrans & ccwrite);
    assign fwd_s       = (state_r == C2C);

    // Granted request still present (a halt or dropped request abandons the transaction).
    always_comb begin
        req_ok_s = 1'b0;
        case (state_r)
            WB:              req_ok_s = |(gnt_oh_s & dWEN & ~halted);
            SNOOP, MEM, C2C: req_ok_s = |(gnt_oh_s & dREN & ~halted);
            IFETCH:          req_ok_s = |(gnt_oh_s & iREN & ~halted);
            default:         req_ok_s = 1'b0;
        endcase
    end

    // Next-state and bus outputs.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        drr_s    = drr_r;
        irr_s    = irr_r;
        gnt_s    = gnt_r;
        own_s    = own_r;
        peer_s   = peer_r;
        inv_s    = inv_r;
        iwait    = {CPUS{1'b1}};
        dwait    = {CPUS{1'b1}};
        ccwait   = {CPUS{1'b0}};
        ccinv    = {CPUS{1'b0}};
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {AW{1'b0}};
        ramstore = {DW{1'b0}};
        case (state_r)
            IDLE: begin
                if (|d_elig_s) begin
                    state_s = ARB;
                end else if (i_pick_s[PW]) begin
                    gnt_s   = i_pick_s[PW-1:0];
                    state_s = IFETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            ARB: begin
                if (d_pick_s[PW]) begin
                    gnt_s   = d_pick_s[PW-1:0];
                    cnt_s   = {CW{1'b0}};
                    state_s = (|(onehot(d_pick_s[PW-1:0]) & dWEN & ~halted)) ? WB : SNOOP;
                end else begin
                    state_s = IDLE;
                end
            end
            SNOOP: begin
                ccwait = peer_set_s;
                ccinv  = g_write_s ? peer_set_s : {CPUS{1'b0}};
                peer_s = peer_set_s;
                inv_s  = g_write_s;
                if (!req_ok_s) begin
                    state_s = IDLE;
                end else if (hit_pick_s[PW]) begin
                    own_s   = hit_pick_s[PW-1:0];
                    state_s = C2C;
                end else begin
                    state_s = MEM;
                end
            end
            WB, MEM, C2C: begin
                ramaddr = gnt_addr_s;
                if (state_r == WB) begin
                    ramWEN   = req_ok_s;
                    ramstore = gnt_store_s;
                end else if (state_r == MEM) begin
                    ccwait = peer_r;
                    ramREN = req_ok_s;
                end else begin
                    // Owner's data goes to the requester and to RAM in the same beat.
                    ccwait   = peer_r;
                    ccinv    = inv_r ? own_oh_s : {CPUS{1'b0}};
                    ramWEN   = req_ok_s;
                    ramstore = own_store_s;
                end
                if (!req_ok_s) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = IDLE;
                end else if (ramready) begin
                    dwait = fwd_s ? ~(gnt_oh_s | own_oh_s) : ~gnt_oh_s;
                    if (cnt_r == LAST_WORD) begin
                        cnt_s   = {CW{1'b0}};
                        drr_s   = gnt_r;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            IFETCH: begin
                ramREN  = req_ok_s;
                ramaddr = gnt_iaddr_s;
                if (!req_ok_s) begin
                    state_s = IDLE;
                end else if (ramready) begin
                    iwait   = ~gnt_oh_s;
                    irr_s   = gnt_r;
                    state_s = IDLE;
                end else begin
                    state_s = IFETCH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            drr_r   <= PTR_RST;
            irr_r   <= PTR_RST;
            gnt_r   <= {PW{1'b0}};
            own_r   <= {PW{1'b0}};
            peer_r  <= {CPUS{1'b0}};
            inv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            drr_r   <= drr_s;
            irr_r   <= irr_s;
            gnt_r   <= gnt_s;
            own_r   <= own_s;
            peer_r  <= peer_s;
            inv_r   <= inv_s;
        end
    end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed-vector bench for coherence_bus_arbiter with four cores and two-word blocks.
`timescale 1ns/1ps
module tb_coherence_bus_arbiter;
    localparam int CPUS = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 2;

    logic               CLK = 1'b0;
    logic               nRST;
    logic [CPUS-1:0]    halted, iREN, dREN, dWEN, cctrans, ccwrite, cchit;
    logic [CPUS-1:0]    iwait, dwait, ccwait, ccinv;
    logic [CPUS*AW-1:0] iaddr, daddr, ccsnoopaddr;
    logic [CPUS*DW-1:0] dstore, iload, dload;
    logic               ramREN, ramWEN, ramready;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore, ramload;

    int vec_cnt = 0;
    int err_cnt = 0;

    coherence_bus_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW), .BLOCK_WORDS(BW)) dut (
        .CLK(CLK), .nRST(nRST), .halted(halted),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .cchit(cchit),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [CPUS*32-1:0] v, input int c);
        return v[c*32 +: 32];
    endfunction

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; halted = '0; iREN = '0; dREN = '0; dWEN = '0;
        cctrans = '0; ccwrite = '0; cchit = '0; iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'h0; ramready = 1'b1;
        #3;
        check_eq("rst_iwait", {28'h0, iwait}, 32'hF);
        check_eq("rst_dwait", {28'h0, dwait}, 32'hF);
        check_eq("rst_ccwait", {28'h0, ccwait}, 32'h0);
        check_eq("rst_ccinv", {28'h0, ccinv}, 32'h0);
        check_eq("rst_ram_en", {30'h0, ramREN, ramWEN}, 32'h0);
        check_eq("rst_ramaddr", ramaddr, 32'h0);
        check_eq("rst_ramstore", ramstore, 32'h0);
        check_eq("rst_snoopaddr", word_of(ccsnoopaddr, 1), 32'h0);
        #9 nRST = 1'b1;

        // Two simultaneous misses: core 0 first, then core 1
        cyc(); dREN = 4'b0011; daddr[0*AW +: AW] = 32'h40; daddr[1*AW +: AW] = 32'h80; #1;
        check_eq("s1_idle_dwait", {28'h0, dwait}, 32'hF);
        cyc(); cyc(); #1;
        check_eq("s1_snoop_ccwait", {28'h0, ccwait}, 32'hE);
        check_eq("s1_snoop_addr", word_of(ccsnoopaddr, 1), 32'h40);
        check_eq("s1_snoop_ccinv", {28'h0, ccinv}, 32'h0);
        cyc(); ramload = 32'hD0; #1;
        check_eq("s1_w0_ramren", {31'h0, ramREN}, 32'h1);
        check_eq("s1_w0_ramaddr", ramaddr, 32'h40);
        check_eq("s1_w0_dwait", {28'h0, dwait}, 32'hE);
        check_eq("s1_w0_dload", word_of(dload, 0), 32'hD0);
        cyc(); daddr[0*AW +: AW] = 32'h44; ramload = 32'hD1; #1;
        check_eq("s1_w1_ramren", {31'h0, ramREN}, 32'h1);
        check_eq("s1_w1_ramaddr", ramaddr, 32'h44);
        check_eq("s1_w1_dwait", {28'h0, dwait}, 32'hE);
        check_eq("s1_w1_dload", word_of(dload, 0), 32'hD1);
        cyc(); dREN = 4'b0010; #1;
        check_eq("s1_gap_dwait", {28'h0, dwait}, 32'hF);
        check_eq("s1_gap_ccwait", {28'h0, ccwait}, 32'h0);
        check_eq("s1_gap_ramren", {31'h0, ramREN}, 32'h0);
        cyc(); cyc(); #1;
        check_eq("s1_c1_ccwait", {28'h0, ccwait}, 32'hD);
        cyc(); #1;
        check_eq("s1_c1_w0_dwait", {28'h0, dwait}, 32'hD);
        check_eq("s1_c1_w0_ramaddr", ramaddr, 32'h80);
        cyc(); #1;
        check_eq("s1_c1_w1_dwait", {28'h0, dwait}, 32'hD);
        cyc(); dREN = 4'b0000; #1;
        check_eq("s1_end_dwait", {28'h0, dwait}, 32'hF);

        // Write-intent miss by core 2, core 3 owns the block Modified
        cyc(); dREN = 4'b0100; daddr[2*AW +: AW] = 32'h100; cctrans = 4'b0100; ccwrite = 4'b0100;
        cchit = 4'b1000; dstore[3*DW +: DW] = 32'hAAAA; #1;
        check_eq("s2_idle_dwait", {28'h0, dwait}, 32'hF);
        cyc(); cyc(); #1;
        check_eq("s2_snoop_ccinv", {28'h0, ccinv}, 32'hB);
        check_eq("s2_snoop_ccwait", {28'h0, ccwait}, 32'hB);
        check_eq("s2_snoop_addr3", word_of(ccsnoopaddr, 3), 32'h100);
        cyc(); #1;
        check_eq("s2_w0_ram_en", {30'h0, ramREN, ramWEN}, 32'h1);
        check_eq("s2_w0_ramstore", ramstore, 32'hAAAA);
        check_eq("s2_w0_dload2", word_of(dload, 2), 32'hAAAA);
        check_eq("s2_w0_dwait", {28'h0, dwait}, 32'h3);
        check_eq("s2_w0_ramaddr", ramaddr, 32'h100);
        check_eq("s2_w0_ccinv", {28'h0, ccinv}, 32'h8);
        check_eq("s2_w0_ccwait", {28'h0, ccwait}, 32'hB);
        cyc(); dstore[3*DW +: DW] = 32'hBBBB; daddr[2*AW +: AW] = 32'h104; #1;
        check_eq("s2_w1_ramstore", ramstore, 32'hBBBB);
        check_eq("s2_w1_dload2", word_of(dload, 2), 32'hBBBB);
        check_eq("s2_w1_dwait", {28'h0, dwait}, 32'h3);
        cyc(); dREN = '0; cctrans = '0; ccwrite = '0; cchit = '0; #1;
        check_eq("s2_end_ccwait", {28'h0, ccwait}, 32'h0);
        check_eq("s2_end_ramwen", {31'h0, ramWEN}, 32'h0);
        check_eq("s2_end_dwait", {28'h0, dwait}, 32'hF);

        // Write-back from core 1, RAM ready every third cycle
        cyc(); ramready = 1'b0; dWEN = 4'b0010; daddr[1*AW +: AW] = 32'h200; dstore[1*DW +: DW] = 32'h11; #1;
        cyc(); cyc(); #1;
        check_eq("s3_a_ramwen", {31'h0, ramWEN}, 32'h1);
        check_eq("s3_a_ramaddr", ramaddr, 32'h200);
        check_eq("s3_a_ramstore", ramstore, 32'h11);
        check_eq("s3_a_dwait", {28'h0, dwait}, 32'hF);
        check_eq("s3_a_ccwait", {28'h0, ccwait}, 32'h0);
        cyc(); #1;
        check_eq("s3_b_dwait", {28'h0, dwait}, 32'hF);
        cyc(); ramready = 1'b1; #1;
        check_eq("s3_c_dwait", {28'h0, dwait}, 32'hD);
        cyc(); ramready = 1'b0; daddr[1*AW +: AW] = 32'h204; dstore[1*DW +: DW] = 32'h22; #1;
        check_eq("s3_d_dwait", {28'h0, dwait}, 32'hF);
        check_eq("s3_d_ramstore", ramstore, 32'h22);
        check_eq("s3_d_ramwen", {31'h0, ramWEN}, 32'h1);
        cyc(); cyc(); ramready = 1'b1; #1;
        check_eq("s3_f_dwait", {28'h0, dwait}, 32'hD);
        check_eq("s3_f_ramaddr", ramaddr, 32'h204);
        check_eq("s3_f_ccwait", {28'h0, ccwait}, 32'h0);
        cyc(); dWEN = '0; #1;
        check_eq("s3_end_ramwen", {31'h0, ramWEN}, 32'h0);

        // Fetch from core 0 and miss from core 1 together: data first
        cyc(); iREN = 4'b0001; iaddr[0*AW +: AW] = 32'h300; dREN = 4'b0010; daddr[1*AW +: AW] = 32'h400; #1;
        check_eq("s4_idle_iwait", {28'h0, iwait}, 32'hF);
        cyc(); cyc(); #1;
        check_eq("s4_snoop_ccwait", {28'h0, ccwait}, 32'hD);
        check_eq("s4_snoop_iwait", {28'h0, iwait}, 32'hF);
        cyc(); #1;
        check_eq("s4_w0_dwait", {28'h0, dwait}, 32'hD);
        check_eq("s4_w0_ramaddr", ramaddr, 32'h400);
        check_eq("s4_w0_iwait", {28'h0, iwait}, 32'hF);
        cyc(); #1;
        check_eq("s4_w1_iwait", {28'h0, iwait}, 32'hF);
        cyc(); dREN = '0; #1;
        check_eq("s4_idle2_iwait", {28'h0, iwait}, 32'hF);
        cyc(); ramload = 32'hF00D; #1;
        check_eq("s4_if_ramren", {31'h0, ramREN}, 32'h1);
        check_eq("s4_if_ramaddr", ramaddr, 32'h300);
        check_eq("s4_if_iwait", {28'h0, iwait}, 32'hE);
        check_eq("s4_if_iload", word_of(iload, 0), 32'hF00D);
        cyc(); iREN = '0; #1;
        check_eq("s4_end_iwait", {28'h0, iwait}, 32'hF);

        // Halted core 1 is neither snooped, invalidated nor granted
        cyc(); halted = 4'b0010; dREN = 4'b0011; daddr[0*AW +: AW] = 32'h500; cchit = 4'b0010;
        cctrans = 4'b0001; ccwrite = 4'b0001; #1;
        cyc(); cyc(); #1;
        check_eq("s5_snoop_ccwait", {28'h0, ccwait}, 32'hC);
        check_eq("s5_snoop_ccinv", {28'h0, ccinv}, 32'hC);
        cyc(); #1;
        check_eq("s5_w0_ram_en", {30'h0, ramREN, ramWEN}, 32'h2);
        check_eq("s5_w0_dwait", {28'h0, dwait}, 32'hE);
        check_eq("s5_w0_ccwait", {28'h0, ccwait}, 32'hC);
        cyc(); #1;
        check_eq("s5_w1_dwait", {28'h0, dwait}, 32'hE);
        cyc(); dREN = 4'b0010; cchit = '0; cctrans = '0; ccwrite = '0; #1;
        check_eq("s5_idle_dwait", {28'h0, dwait}, 32'hF);
        cyc(); #1;
        check_eq("s5_ignored_ramren", {31'h0, ramREN}, 32'h0);
        check_eq("s5_ignored_ccwait", {28'h0, ccwait}, 32'h0);
        cyc(); halted = '0; dREN = '0; #1;

        // Reset during the second C2C word, then the request restarts from word 0
        cyc(); dREN = 4'b0100; daddr[2*AW +: AW] = 32'h600; cchit = 4'b1000; dstore[3*DW +: DW] = 32'hCC; #1;
        cyc(); cyc(); cyc(); #1;
        check_eq("s6_w0_dwait", {28'h0, dwait}, 32'h3);
        cyc(); dstore[3*DW +: DW] = 32'hDD; daddr[2*AW +: AW] = 32'h604; #1;
        nRST = 1'b0; #1;
        check_eq("s6_rst_dwait", {28'h0, dwait}, 32'hF);
        check_eq("s6_rst_iwait", {28'h0, iwait}, 32'hF);
        check_eq("s6_rst_ramwen", {31'h0, ramWEN}, 32'h0);
        check_eq("s6_rst_ccwait", {28'h0, ccwait}, 32'h0);
        dstore[3*DW +: DW] = 32'hCC; daddr[2*AW +: AW] = 32'h600;
        #1 nRST = 1'b1;
        cyc(); #1;
        check_eq("s6_arb_dwait", {28'h0, dwait}, 32'hF);
        check_eq("s6_arb_ccwait", {28'h0, ccwait}, 32'h0);
        cyc(); #1;
        check_eq("s6_snoop_ccwait", {28'h0, ccwait}, 32'hB);
        cyc(); #1;
        check_eq("s6_rw0_ramstore", ramstore, 32'hCC);
        check_eq("s6_rw0_ramaddr", ramaddr, 32'h600);
        check_eq("s6_rw0_dwait", {28'h0, dwait}, 32'h3);
        cyc(); dstore[3*DW +: DW] = 32'hDD; daddr[2*AW +: AW] = 32'h604; #1;
        check_eq("s6_rw1_ramwen", {31'h0, ramWEN}, 32'h1);
        check_eq("s6_rw1_ramstore", ramstore, 32'hDD);
        check_eq("s6_rw1_dwait", {28'h0, dwait}, 32'h3);
        cyc(); dREN = '0; cchit = '0; #1;
        check_eq("s6_end_ramwen", {31'h0, ramWEN}, 32'h0);
        check_eq("s6_end_ccwait", {28'h0, ccwait}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
